// File: rtl/csa_resolve.sv
`default_nettype none
// ============================================================================
// Module   : csa_resolve
// Purpose  : Sequential carry-propagate resolver for a carry-save pair.
//            Returns (ps + (pc << 1)) mod 2^N. The add is done CHUNK bits per
//            cycle, and a registered carry passes between chunks.
//            cout reports any overflow at or above bit N.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - operand handshake (ps, pc)
//            ps [N-1:0]      - partial sum vector
//            pc [N-1:0]      - partial carry vector (bit i has weight 2^(i+1))
//            out_valid/ready - result handshake (sum, cout)
//            sum [N-1:0]     - resolved low N bits
//            cout            - 1 when the true value is >= 2^N
// Revision : 1.0 - initial release
// ============================================================================
module csa_resolve #(
    parameter int N     = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] ps,
    input  logic [N-1:0] pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int K  = N / CHUNK;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam logic [KW-1:0] c_K_LAST = KW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [N-1:0]    r_ps;
    logic [N-1:0]    r_pc;      // pc already shifted into its true weight
    logic            r_hi;      // pc[N-1], which lands at bit N after the shift
    logic            r_carry;
    logic [KW-1:0]   r_k;
    logic [N-1:0]    r_sum;
    logic            r_cout;

    logic            w_accept;
    logic            w_last;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK:0]  w_add;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_k == c_K_LAST);

    // One CHUNK-wide adder. The carry chain never spans more than one chunk.
    assign w_a   = r_ps[r_k*CHUNK +: CHUNK];
    assign w_b   = r_pc[r_k*CHUNK +: CHUNK];
    assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{CHUNK{1'b0}}, r_carry};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_RUN;
            S_RUN:   if (w_last)   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The operand latches carry no reset: they are loaded at every accept
    // and are never observed before that.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ps <= ps;
            r_pc <= {pc[N-2:0], 1'b0};
            r_hi <= pc[N-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_carry <= 1'b0;
                r_k     <= '0;
            end else if (r_state == S_RUN) begin
                r_sum[r_k*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
                r_carry <= w_add[CHUNK];
                if (w_last) begin
                    // The shifted-out pc MSB alone already means the value
                    // is at least 2^N.
                    r_cout <= w_add[CHUNK] | r_hi;
                end else begin
                    r_k <= r_k + KW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_resolve
// Purpose  : Self-checking bench for csa_resolve. It builds three instances
//            with CHUNK = 16, 8 and 64. Each one runs directed cases and then
//            throttled random traffic. A scoreboard checks every result
//            against an arithmetic reference: {cout,sum} = ps + 2*pc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_resolve;

    localparam int N     = 64;
    localparam int NRAND = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [N:0] act, input logic [N:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Reference value: full-precision add, then fold everything at or above
    // bit N into the overflow flag.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N+1:0] v;
        v = {2'b00, a} + ({2'b00, b} << 1);
        return {|v[N+1:N], v[N-1:0]};
    endfunction

    function automatic logic [N-1:0] rnd_op();
        logic [N-1:0] v;
        case ($urandom_range(5))
            0:       v = '1;
            1:       v = {1'b1, {(N-1){1'b0}}};
            2:       v = N'($urandom_range(15));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int CH = (gi == 0) ? 16 : ((gi == 1) ? 8 : 64);
            localparam int K  = N / CH;

            logic         rst       = 1'b1;
            logic         in_valid  = 1'b0;
            logic         in_ready;
            logic [N-1:0] ps        = '0;
            logic [N-1:0] pc        = '0;
            logic         out_valid;
            logic         out_ready = 1'b0;
            logic [N-1:0] sum;
            logic         cout;

            logic         bp_hold = 1'b0;
            logic         bp_rand = 1'b0;
            logic         fin     = 1'b0;
            int           cyc     = 0;
            logic [N:0]   exp_q[$];
            int           acc_q[$];
            string        tag;
            logic         mon_prev = 1'b0;
            logic [N:0]   mon_held = '0;
            logic [N:0]   mon_got;

            csa_resolve #(.N(N), .CHUNK(CH)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .ps        (ps),
                .pc        (pc),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .sum       (sum),
                .cout      (cout)
            );

            always @(posedge clk) cyc <= cyc + 1;

            always @(posedge clk) begin
                #1;
                out_ready = bp_hold ? 1'b0 : (bp_rand ? ($urandom_range(3) != 0) : 1'b1);
            end

            task automatic step();
                @(posedge clk);
                #1;
            endtask

            // Present one operand pair until it is accepted, then scramble
            // the inputs to show that only the accept edge samples them.
            task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
                logic got;
                got      = 1'b0;
                ps       = a;
                pc       = b;
                in_valid = 1'b1;
                for (int t = 0; t < 300 && !got; t++) begin
                    @(negedge clk);
                    if (in_ready) begin
                        exp_q.push_back(model(a, b));
                        acc_q.push_back(cyc + 1);
                        got = 1'b1;
                    end
                    step();
                end
                in_valid = 1'b0;
                ps       = {$urandom, $urandom};
                pc       = {$urandom, $urandom};
                check({tag, " accept"}, (N+1)'(got), (N+1)'(1));
            endtask

            task automatic drain();
                bp_hold = 1'b0;
                bp_rand = 1'b0;
                for (int t = 0; t < 500 && exp_q.size() != 0; t++) step();
                check({tag, " drained"}, (N+1)'(exp_q.size()), (N+1)'(0));
            endtask

            // Scoreboard monitor
            initial begin
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        mon_prev = 1'b0;
                    end else begin
                        if (out_valid) begin
                            mon_got = {cout, sum};
                            check({tag, " in_ready in DONE"}, (N+1)'(in_ready), (N+1)'(0));
                            if (!mon_prev) begin
                                mon_held = mon_got;
                                if (acc_q.size() > 0)
                                    check({tag, " latency"}, (N+1)'(cyc - acc_q.pop_front()), (N+1)'(K));
                                else
                                    fail_now({tag, " unexpected out_valid"});
                            end else begin
                                check({tag, " held stable"}, mon_got, mon_held);
                            end
                            if (out_ready) begin
                                if (exp_q.size() > 0)
                                    check({tag, " result"}, mon_got, exp_q.pop_front());
                                else
                                    fail_now({tag, " result with empty scoreboard"});
                            end
                        end
                        mon_prev = out_valid && !out_ready;
                    end
                end
            end

            // Stimulus
            initial begin
                int w;
                tag = $sformatf("CH%0d", CH);

                // Reset state
                repeat (2) step();
                @(negedge clk);
                check({tag, " rst out_valid"}, (N+1)'(out_valid), (N+1)'(0));
                check({tag, " rst sum/cout"}, {cout, sum}, (N+1)'(0));
                check({tag, " rst in_ready"}, (N+1)'(in_ready), (N+1)'(0));
                step();
                rst = 1'b0;
                @(negedge clk);
                check({tag, " in_ready after rst"}, (N+1)'(in_ready), (N+1)'(1));
                step();

                // Directed arithmetic cases
                issue(64'h5, 64'h3);                     drain();
                issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);   drain();
                issue(64'h0, 64'h8000_0000_0000_0000);   drain();
                issue(64'h1, 64'h8000_0000_0000_0000);   drain();
                issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF); drain();

                // Backpressure: the result waits while ignored operands are offered
                bp_hold = 1'b1;
                step();
                issue({$urandom, $urandom}, {$urandom, $urandom});
                w = 0;
                while (!out_valid && w < 300) begin
                    step();
                    w++;
                end
                check({tag, " bp out_valid rose"}, (N+1)'(out_valid), (N+1)'(1));
                for (int c = 0; c < 6; c++) begin
                    if (c < 2) begin
                        in_valid = 1'b1;
                        ps       = rnd_op();
                        pc       = rnd_op();
                    end else begin
                        in_valid = 1'b0;
                    end
                    @(negedge clk);
                    check({tag, " bp in_ready"}, (N+1)'(in_ready), (N+1)'(0));
                    check({tag, " bp out_valid"}, (N+1)'(out_valid), (N+1)'(1));
                    step();
                end
                in_valid = 1'b0;
                drain();
                issue(rnd_op(), rnd_op());
                drain();

                // Reset while the operation is running
                issue({$urandom, $urandom}, {$urandom, $urandom});
                rst = 1'b1;
                step();
                exp_q.delete();
                acc_q.delete();
                @(negedge clk);
                check({tag, " midrst out_valid"}, (N+1)'(out_valid), (N+1)'(0));
                check({tag, " midrst sum/cout"}, {cout, sum}, (N+1)'(0));
                check({tag, " midrst in_ready"}, (N+1)'(in_ready), (N+1)'(0));
                step();
                rst = 1'b0;
                @(negedge clk);
                check({tag, " in_ready after midrst"}, (N+1)'(in_ready), (N+1)'(1));
                step();
                issue(rnd_op(), rnd_op());
                drain();

                // Random traffic with throttling on both sides
                bp_rand = 1'b1;
                for (int t = 0; t < NRAND; t++) begin
                    repeat ($urandom_range(2)) step();
                    issue(rnd_op(), rnd_op());
                end
                drain();
                fin = 1'b1;
            end
        end
    endgenerate

    initial begin
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
        end
        check("all configurations finished",
              (N+1)'({g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin}), (N+1)'(7));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa_resolve.md
# csa_resolve

Sequential carry-propagate resolver for the Wallace multiplier datapath. It accepts one carry-save pair (partial sum `ps`, partial carry `pc`) as produced by the CSA reduction stages. It returns the binary value `ps + (pc << 1)`, computed CHUNK bits per cycle with a registered inter-chunk carry. It is the consumer of the redundant form: it sits after the last CSA level and replaces a single-cycle full-width adder, using valid/ready handshakes on both sides.

## Interface
- `N`, 64: operand and result width; `N % CHUNK == 0` required.
- `CHUNK`, 16: bits resolved per cycle, 1..N. K = N/CHUNK beats per operation.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  carry-save operand pair present.
- `in_ready`  out  1  block can accept operands.
- `ps`  in  N  partial sum vector.
- `pc`  in  N  partial carry vector, weight 2^(i+1) for bit i.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts result.
- `sum`  out  N  `(ps + (pc << 1)) mod 2^N`.
- `cout`  out  1  1 when the true value is ≥ 2^N.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. On `in_valid`: latch `ps`, and `pc` shifted left by 1 (bit 0 = 0). Also latch `pc[N-1]` as `hi_bit`, and clear the carry register and chunk index k. Go to RUN.
  - RUN: each cycle add latched chunk k of ps and of shifted pc, plus the carry register. Write the CHUNK-bit result into `sum[k*CHUNK +: CHUNK]`. Update the carry register and increment k. When k = K-1 is processed: set `cout = carry_out | hi_bit` and go to DONE.
  - DONE: `out_valid`=1. `sum` and `cout` are held stable. On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` in RUN/DONE is ignored and no operand is captured.
- Operand inputs are sampled only on the accept edge. Later changes on `ps` and `pc` have no effect.
- Arithmetic is unsigned. The true value is < 2^(N+1) + 2^N. Only overflow presence is reported, on `cout`; bits above N-1 are not reported.
- `sum` bits not yet written in RUN hold stale values. They are not observable because `out_valid` is 0.
- Reset (any state, including mid-RUN): state→IDLE, k=0, carry=0, `sum`=0, `cout`=0, `out_valid`=0. The in-flight operation is discarded and no result is emitted.
- `in_ready` is 0 while `rst` is high.

## Timing
- Accept edge E0 (`in_valid & in_ready`): RUN starts in the next cycle.
- Chunks are written at edges E1..EK. DONE is entered at EK, and `out_valid` is high in the cycle after EK.
- Latency: K cycles from the accept edge to `out_valid`. Default K=4. With CHUNK=N, K=1.
- Result transfer happens at the edge where `out_valid & out_ready`. `in_ready` is high in the following cycle.
- Minimum initiation interval: K+2 cycles per operation (accept, K beats, result handshake). Input and output handshakes do not overlap.
- `out_ready` held low: the block stays in DONE indefinitely with outputs constant.
- `out_ready` high before `out_valid`: it has no effect until DONE.
- Critical path: one CHUNK-bit add plus carry mux. There is no full-width combinational carry chain.

## Test plan
- Basic: `ps`=0x5, `pc`=0x3 → `sum`=0xB, `cout`=0, with `out_valid` exactly 4 cycles after accept (N=64, CHUNK=16).
- Cross-chunk ripple: `ps`=0xFFFF_FFFF_FFFF_FFFF, `pc`=0x1 → `sum`=0x1, `cout`=1. Carry must propagate through all 4 chunks.
- Top carry bit: `ps`=0, `pc`=0x8000_0000_0000_0000 → `sum`=0, `cout`=1. Also `pc`=0x8000_0000_0000_0000, `ps`=0x1 → `sum`=0x1, `cout`=1.
- Backpressure: hold `out_ready`=0 for 6 cycles after `out_valid` rises. Required: `sum`/`cout` stable, `in_ready`=0. A new `in_valid` pulse with different operands is not captured, and the next accepted result matches only operands presented after `in_ready` returns.
- Reset mid-operation: assert `rst` one cycle into RUN. Required: `out_valid`=0, `sum`=0, `cout`=0 after the reset edge, and `in_ready`=1 the cycle after `rst` deasserts. The following operation resolves correctly.
- Random: 2000 random `ps`/`pc` pairs with random `in_valid`/`out_ready` throttling, checked against the model `{cout,sum} = ps + 2*pc` (`cout` = any bit ≥ N set). Run at CHUNK=16, 8 and 64.
